nvdla_csb_slave_bridge: RTL

Parametrised CSB slave front end for NVDLA sub-units (MCIF, CVIF and later clients): it accepts 63-bit CSB request packets, drives a generic register-bank port with byte enables and configurable read latency, and returns 34-bit responses. Unlike the fixed-ready generation, it supports response backpressure through a credit-limited response FIFO. It also flags out-of-range addresses with an error response and keeps a saturating error counter. It sits between the CSB master and each unit's register file.

---
 rtl/nvdla_csb_slave_bridge.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/nvdla_csb_slave_bridge.sv
// CSB request -> register-bank bridge; strobe 1 cycle after accept, response RD_LAT+2 cycles after accept.
// Request ready is credit-gated by outstanding responses, so the response FIFO absorbs xx2csb_resp_ready stalls.
module nvdla_csb_slave_bridge #(
   parameter int ADDR_W    = 10,
   parameter int NUM_REGS  = 32,
   parameter int RD_LAT    = 0,
   parameter int RSP_DEPTH = 2
) (
   input  logic                nvdla_core_clk,
   input  logic                nvdla_core_rstn,
   input  logic                csb2xx_req_pvld,
   output logic                csb2xx_req_prdy,
   input  logic [62:0]         csb2xx_req_pd,
   output logic                xx2csb_resp_valid,
   input  logic                xx2csb_resp_ready,
   output logic [33:0]         xx2csb_resp_pd,
   output logic [ADDR_W+1:0]   reg_offset,
   output logic                reg_wr_en,
   output logic [3:0]          reg_wr_be,
   output logic [31:0]         reg_wr_data,
   output logic                reg_rd_en,
   input  logic [31:0]         reg_rd_data,
   output logic [7:0]          err_cnt
);

   localparam int OCC_W = $clog2(RSP_DEPTH + 1);
   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

   typedef struct packed {
      logic        typ;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   logic              req_accept;
   logic              req_needs_rsp;
   logic              req_vld;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdat;
   logic              req_write;
   logic              req_nposted;
   logic [3:0]        req_be;
   logic              in_range;
   logic              iss_vld;
   logic              iss_err;
   logic              push_vld;
   logic              push_err;
   logic              push_typ;
   rsp_t              push_rsp;
   logic              pop;
   logic [OCC_W-1:0]  occ;
   logic [OCC_W-1:0]  cnt;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   rsp_t              mem [RSP_DEPTH];
   logic              unused_pd;

   // srcpriv, level and address bits above the decoded window are ignored
   assign unused_pd = ^{csb2xx_req_pd[62:61], csb2xx_req_pd[56], csb2xx_req_pd[21:ADDR_W]};

   assign csb2xx_req_prdy = (occ < OCC_W'(RSP_DEPTH));
   assign req_accept      = csb2xx_req_pvld & csb2xx_req_prdy;
   assign req_needs_rsp   = ~csb2xx_req_pd[54] | csb2xx_req_pd[55];

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         req_vld     <= 1'b0;
         req_addr    <= '0;
         req_wdat    <= '0;
         req_write   <= 1'b0;
         req_nposted <= 1'b0;
         req_be      <= '0;
      end else begin
         req_vld <= req_accept;
         if (req_accept) begin
            req_addr    <= csb2xx_req_pd[ADDR_W-1:0];
            req_wdat    <= csb2xx_req_pd[53:22];
            req_write   <= csb2xx_req_pd[54];
            req_nposted <= csb2xx_req_pd[55];
            req_be      <= csb2xx_req_pd[60:57];
         end
      end
   end

   assign in_range    = (32'(req_addr) < NUM_REGS[31:0]);
   assign reg_offset  = {req_addr, 2'b00};
   assign reg_wr_be   = req_be;
   assign reg_wr_data = req_wdat;
   assign reg_wr_en   = req_vld & req_write & in_range;
   assign reg_rd_en   = req_vld & ~req_write & in_range;
   assign iss_vld     = req_vld & (~req_write | req_nposted);
   assign iss_err     = ~in_range;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         err_cnt <= '0;
      end else if (req_vld && !in_range && err_cnt != 8'hFF) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

   // Every response rides the read-latency pipe so write/error responses keep request order
   generate
      if (RD_LAT == 0) begin : g_nopipe
         assign push_vld = iss_vld;
         assign push_err = iss_err;
         assign push_typ = req_write;
      end else begin : g_pipe
         logic [RD_LAT-1:0][2:0] sh;
         always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
            if (!nvdla_core_rstn) begin
               sh <= '0;
            end else begin
               sh[0] <= {iss_vld, iss_err, req_write};
               for (int i = 1; i < RD_LAT; i++) begin
                  sh[i] <= sh[i-1];
               end
            end
         end
         assign {push_vld, push_err, push_typ} = sh[RD_LAT-1];
      end
   endgenerate

   assign push_rsp.typ   = push_typ;
   assign push_rsp.err   = push_err;
   assign push_rsp.rdata = (push_typ | push_err) ? 32'h0 : reg_rd_data;

   function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign xx2csb_resp_valid = (cnt != '0);
   assign xx2csb_resp_pd    = xx2csb_resp_valid ? mem[rd_ptr] : '0;
   assign pop               = xx2csb_resp_valid & xx2csb_resp_ready;

   always_ff @(posedge nvdla_core_clk) begin
      if (push_vld) begin
         mem[wr_ptr] <= push_rsp;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         occ    <= '0;
      end else begin
         if (push_vld) wr_ptr <= ptr_nxt(wr_ptr);
         if (pop)      rd_ptr <= ptr_nxt(rd_ptr);
         if (push_vld && !pop)      cnt <= cnt + 1'b1;
         else if (!push_vld && pop) cnt <= cnt - 1'b1;
         if (req_accept && req_needs_rsp && !pop)      occ <= occ + 1'b1;
         else if (!(req_accept && req_needs_rsp) && pop) occ <= occ - 1'b1;
      end
   end

   // Credits bound FIFO fill; a push into a full FIFO means the credit loop is broken
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rstn) begin
         rsp_no_overflow: assert (!(push_vld && !pop && cnt == OCC_W'(RSP_DEPTH)));
      end
   end

endmodule
